// File: rtl/apb3_master_if.sv
// APB3 initiator bundle: command, write-data and read-data streams, completion status and APB3 bus.
// Pure wiring, no latency.
// Backpressure is carried on the cmd/wr/rd valid-ready pairs and on PREADY.
interface apb3_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_write;
    logic [LEN_WIDTH-1:0]  cmd_len;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;

    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_err;

    logic                  done;
    logic                  done_err;
    logic                  busy;

    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERROR;

    // Initiator view
    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_len,
        output cmd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output rd_valid, rd_data, rd_err,
        input  rd_ready,
        output done, done_err, busy,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERROR
    );

    // Environment view (command source, data source/sink, APB slave)
    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_len,
        input  cmd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  rd_valid, rd_data, rd_err,
        output rd_ready,
        input  done, done_err, busy,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERROR
    );
endinterface

// File: rtl/apb3_master.sv
// Single-outstanding APB3 initiator: command -> sequential word APB3 transfers, auto-incrementing address.
// Latency: 4 cycles per beat minimum (read SETUP/ACCESS/RESP/NEXT, write FETCH/SETUP/ACCESS/NEXT); done one cycle after NEXT.
// Backpressure: stalls in FETCH on wr_valid, ACCESS on PREADY, RESP on rd_ready. Macro APB3_MASTER_TIMEOUT_EN adds an ACCESS timeout.
module apb3_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
`ifdef APB3_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 255
`endif
) (
    input  logic           clk,
    input  logic           resetn,
    apb3_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        RESP   = 3'd4,
        NEXT   = 3'd5
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(DATA_WIDTH / 8);

    state_t               state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] beat;
    logic                 err_acc;

    // Beat termination as seen by the FSM (PREADY, or a forced timeout)
    logic                  beat_end;
    logic                  beat_err;
    logic [DATA_WIDTH-1:0] beat_rdata;

    // Stream handshakes decoded straight from the state register
    assign bus.cmd_ready = (state == IDLE);
    assign bus.wr_ready  = (state == FETCH);

`ifdef APB3_MASTER_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) < 8)  ? 8  :
                        ($clog2(TIMEOUT + 1) > 16) ? 16 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Counter holds the number of ACCESS cycles already spent on this beat
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    // A stuck slave is treated as an erroring slave returning zero data
    always_comb begin
        beat_end   = bus.PREADY;
        beat_err   = bus.PSLVERROR;
        beat_rdata = bus.PRDATA;
        if (!bus.PREADY && tmo_hit) begin
            beat_end   = 1'b1;
            beat_err   = 1'b1;
            beat_rdata = '0;
        end
    end
`else
    // Without the timeout, only PREADY ends a beat
    always_comb begin
        beat_end   = bus.PREADY;
        beat_err   = bus.PSLVERROR;
        beat_rdata = bus.PRDATA;
    end
`endif

    // Main FSM with registered outputs; outputs are set on entry to the state that presents them
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            len_q        <= '0;
            beat         <= '0;
            err_acc      <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_err   <= 1'b0;
            bus.done     <= 1'b0;
            bus.done_err <= 1'b0;
            bus.busy     <= 1'b0;
            bus.PADDR    <= '0;
            bus.PSEL     <= 1'b0;
            bus.PENABLE  <= 1'b0;
            bus.PWRITE   <= 1'b0;
            bus.PWDATA   <= '0;
`ifdef APB3_MASTER_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            // done/done_err are a single-cycle strobe
            bus.done     <= 1'b0;
            bus.done_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.PADDR  <= bus.cmd_addr;
                        bus.PWRITE <= bus.cmd_write;
                        len_q      <= bus.cmd_len;
                        beat       <= '0;
                        err_acc    <= 1'b0;
                        bus.busy   <= 1'b1;
                        if (bus.cmd_write) begin
                            state <= FETCH;
                        end else begin
                            bus.PSEL <= 1'b1;
                            state    <= SETUP;
                        end
                    end
                end

                FETCH: begin
                    if (bus.wr_valid) begin
                        bus.PWDATA <= bus.wr_data;
                        bus.PSEL   <= 1'b1;
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    bus.PENABLE <= 1'b1;
`ifdef APB3_MASTER_TIMEOUT_EN
                    tmo_cnt     <= '0;
`endif
                    state       <= ACCESS;
                end

                ACCESS: begin
                    if (beat_end) begin
                        err_acc     <= err_acc | beat_err;
                        bus.PSEL    <= 1'b0;
                        bus.PENABLE <= 1'b0;
                        if (bus.PWRITE) begin
                            state <= NEXT;
                        end else begin
                            bus.rd_data  <= beat_rdata;
                            bus.rd_err   <= beat_err;
                            bus.rd_valid <= 1'b1;
                            state        <= RESP;
                        end
                    end
`ifdef APB3_MASTER_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
`endif
                end

                RESP: begin
                    if (bus.rd_ready) begin
                        bus.rd_valid <= 1'b0;
                        state        <= NEXT;
                    end
                end

                NEXT: begin
                    if (beat == len_q) begin
                        bus.done     <= 1'b1;
                        bus.done_err <= err_acc;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        // Address wraps modulo 2^ADDR_WIDTH
                        bus.PADDR <= bus.PADDR + ADDR_INC;
                        beat      <= beat + LEN_WIDTH'(1);
                        if (bus.PWRITE) begin
                            state <= FETCH;
                        end else begin
                            bus.PSEL <= 1'b1;
                            state    <= SETUP;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb3_master.sv
// Directed bench for apb3_master: command/data streams driven here, APB slave modelled behaviourally.
// Expected APB transfers and read beats are queued when a command is issued and popped as the DUT produces them.
module tb_apb3_master;

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } rbeat_t;

`ifdef APB3_MASTER_TIMEOUT_EN
    localparam int HOLD = 4;
`else
    localparam int HOLD = 40;
`endif

    logic clk = 1'b0;
    logic resetn;

    int vecs = 0;
    int miscompares = 0;

    xfer_t  exp_apb[$];
    xfer_t  obs_apb[$];
    rbeat_t exp_rd[$];

    // Slave model configuration/state
    logic [31:0] wd_tab   [0:255];
    logic [31:0] sl_rdata [0:255];
    bit          sl_err   [0:255];
    int          sl_wait   = 0;
    bit          sl_hang   = 1'b0;
    int          sl_idx    = 0;
    int          sl_wcnt   = 0;
    int          sl_setups = 0;
    int          acc_cnt   = 0;

    apb3_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

    apb3_master #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .LEN_WIDTH (8)
`ifdef APB3_MASTER_TIMEOUT_EN
        ,
        .TIMEOUT   (8)
`endif
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // APB slave: wait states, per-beat error, hang mode; garbage on PRDATA/PSLVERROR when not completing
    always @(negedge clk) begin
        if (bus.PSEL && !bus.PENABLE) sl_setups++;
        if (bus.PSEL && bus.PENABLE) begin
            acc_cnt++;
            if (!sl_hang && sl_wcnt >= sl_wait) begin
                xfer_t x;
                bus.PREADY    = 1'b1;
                bus.PRDATA    = sl_rdata[sl_idx % 256];
                bus.PSLVERROR = sl_err[sl_idx % 256];
                x.addr  = bus.PADDR;
                x.wr    = bus.PWRITE;
                x.wdata = bus.PWRITE ? bus.PWDATA : 32'h0;
                obs_apb.push_back(x);
                sl_idx++;
            end else begin
                bus.PREADY    = 1'b0;
                bus.PRDATA    = 32'hBAD0_BAD0;
                bus.PSLVERROR = 1'b1;
                sl_wcnt++;
            end
        end else begin
            bus.PREADY    = 1'b0;
            bus.PRDATA    = 32'hBAD0_BAD0;
            bus.PSLVERROR = 1'b1;
            sl_wcnt       = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_errs();
        for (int i = 0; i < 256; i++) sl_err[i] = 1'b0;
    endtask

    // Issue one command, feed/consume streams, then score the APB log
    task automatic run_cmd(input logic [15:0] addr, input bit wr, input int len,
                           input int rdly, input bit exp_err, input bit hang);
        xfer_t  x;
        xfer_t  o;
        rbeat_t r;
        int wi, done_cnt, cyc, rwait;
        for (int i = 0; i <= len; i++) begin
            x.addr  = 16'(addr + 16'(4 * i));
            x.wr    = wr;
            x.wdata = wr ? wd_tab[i] : 32'h0;
            if (!hang) exp_apb.push_back(x);
            if (!wr) begin
                r.d = hang ? 32'h0 : sl_rdata[i];
                r.e = hang ? 1'b1 : sl_err[i];
                exp_rd.push_back(r);
            end
        end
        sl_idx = 0; sl_setups = 0; acc_cnt = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_addr = addr; bus.cmd_write = wr; bus.cmd_len = 8'(len);
        chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("busy_after_accept", bus.busy, 1'b1);
        wi = 0; done_cnt = 0; cyc = 0; rwait = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            if (wr && wi <= len) begin
                bus.wr_valid = 1'b1; bus.wr_data = wd_tab[wi];
            end else begin
                bus.wr_valid = 1'b0;
            end
            if (bus.wr_ready && bus.wr_valid) wi++;
            bus.rd_ready = 1'b0;
            if (bus.rd_valid) begin
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected", 1'b1, 1'b0);
                end else if (rwait < rdly) begin
                    chk("rd_data_held", bus.rd_data, exp_rd[0].d);
                    rwait++;
                end else begin
                    r = exp_rd.pop_front();
                    chk("rd_data", bus.rd_data, r.d);
                    chk("rd_err", bus.rd_err, r.e);
                    bus.rd_ready = 1'b1;
                    rwait = 0;
                end
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_err", bus.done_err, exp_err);
            end
            @(negedge clk);
            cyc++;
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        chk("done_seen", done_cnt, 1);
        chk("done_single", bus.done, 1'b0);
        chk("busy_clear", bus.busy, 1'b0);
        chk("rd_all_consumed", exp_rd.size(), 0);
        if (!hang) chk("setup_count", sl_setups, len + 1);
        while (exp_apb.size() > 0) begin
            x = exp_apb.pop_front();
            if (obs_apb.size() == 0) begin
                chk("apb_missing", 1'b1, 1'b0);
            end else begin
                o = obs_apb.pop_front();
                chk("paddr", o.addr, x.addr);
                chk("pwrite", o.wr, x.wr);
                chk("pwdata", o.wdata, x.wdata);
            end
        end
        chk("apb_extra", obs_apb.size(), 0);
    endtask

    initial begin
        int  cyc;
        bit  held;
        bit  no_done;
        resetn        = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_write = 1'b0; bus.cmd_len = '0;
        bus.wr_valid  = 1'b0; bus.wr_data = '0;
        bus.rd_ready  = 1'b0;
        clear_errs();
        for (int i = 0; i < 256; i++) begin
            wd_tab[i]   = 32'hA000_0000 + i;
            sl_rdata[i] = 32'h5000_0000 + i;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_psel", bus.PSEL, 1'b0);
        chk("rst_penable", bus.PENABLE, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_rd_valid", bus.rd_valid, 1'b0);
        chk("rst_wr_ready", bus.wr_ready, 1'b0);
        resetn = 1'b1;

        // Single write
        wd_tab[0] = 32'hDEAD_BEEF; sl_wait = 0;
        run_cmd(16'h0010, 1'b1, 0, 0, 1'b0, 1'b0);

        // Read burst, 2 wait states, rd_ready low 3 cycles per beat
        sl_rdata[0] = 32'h11; sl_rdata[1] = 32'h22; sl_rdata[2] = 32'h33; sl_rdata[3] = 32'h44;
        sl_wait = 2;
        run_cmd(16'h0100, 1'b0, 3, 3, 1'b0, 1'b0);

        // Error on beat 1 only: write then read
        sl_wait = 1; sl_err[1] = 1'b1;
        run_cmd(16'h0200, 1'b1, 2, 0, 1'b1, 1'b0);
        run_cmd(16'h0300, 1'b0, 2, 0, 1'b1, 1'b0);
        clear_errs();

        // Address wrap
        sl_wait = 0;
        run_cmd(16'hFFFC, 1'b0, 1, 1, 1'b0, 1'b0);

        // Maximum length read: 256 beats
        for (int i = 0; i < 256; i++) sl_rdata[i] = $urandom;
        run_cmd(16'h1000, 1'b0, 255, 0, 1'b0, 1'b0);

`ifdef APB3_MASTER_TIMEOUT_EN
        // Stuck slave: beat ends after 8 ACCESS cycles with zero data and error
        sl_hang = 1'b1;
        run_cmd(16'h0040, 1'b0, 0, 0, 1'b1, 1'b1);
        chk("timeout_access_cycles", acc_cnt, 8);
        sl_hang = 1'b0;
`endif

        // Stuck slave held, then reset mid-ACCESS
        sl_hang = 1'b1; sl_idx = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_addr = 16'h0500; bus.cmd_write = 1'b0; bus.cmd_len = 8'd2;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        cyc = 0;
        while (!(bus.PSEL && bus.PENABLE) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("hang_access_reached", bus.PSEL && bus.PENABLE, 1'b1);
        held = 1'b1;
        repeat (HOLD) begin
            @(negedge clk);
            if (!(bus.PSEL && bus.PENABLE)) held = 1'b0;
        end
        chk("hang_psel_held", held, 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        chk("mrst_psel", bus.PSEL, 1'b0);
        chk("mrst_penable", bus.PENABLE, 1'b0);
        chk("mrst_paddr", bus.PADDR, 16'h0);
        chk("mrst_pwrite", bus.PWRITE, 1'b0);
        chk("mrst_pwdata", bus.PWDATA, 32'h0);
        chk("mrst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("mrst_busy", bus.busy, 1'b0);
        chk("mrst_rd_valid", bus.rd_valid, 1'b0);
        chk("mrst_done", bus.done, 1'b0);
        resetn  = 1'b1;
        sl_hang = 1'b0;
        no_done = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) no_done = 1'b0;
        end
        chk("mrst_no_done", no_done, 1'b1);
        exp_apb.delete(); obs_apb.delete(); exp_rd.delete();

        // Fresh command after mid-burst reset
        wd_tab[0] = 32'h0BAD_F00D; wd_tab[1] = 32'h1234_5678;
        run_cmd(16'h0600, 1'b1, 1, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/apb3_master.md
Name: apb3_master

Overview:
- Single-outstanding APB3 initiator; the driving end of the APB3 slave port used on the SoC peripheral bus.
- Converts a simple command stream (address, direction, beat count) into sequential word APB3 transfers with address auto-increment.
- Write data is taken from a valid/ready stream; read data is returned on a valid/ready stream.
- Used to exercise APB3 slaves from fabric logic and benches without a CPU.

Parameters:
ADDR_WIDTH, 16, PADDR and cmd_addr width
DATA_WIDTH, 32, PWDATA/PRDATA width; address increment is DATA_WIDTH/8
LEN_WIDTH, 8, width of cmd_len (beats minus one)
TIMEOUT, 255, ACCESS-phase cycles before forced termination (optional feature only)

Ports:
clk  in  1  single clock; all logic rising-edge
resetn  in  1  synchronous reset, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block idle, command accepted when cmd_valid & cmd_ready
cmd_addr  in  ADDR_WIDTH  first beat address
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_len  in  LEN_WIDTH  beats minus one
wr_valid  in  1  write data present
wr_ready  out  1  write data accepted
wr_data  in  DATA_WIDTH  write beat data
rd_valid  out  1  read beat available
rd_ready  in  1  read beat consumed
rd_data  out  DATA_WIDTH  read beat data
rd_err  out  1  PSLVERROR (or timeout) for this read beat
done  out  1  one-cycle pulse after the final beat completes
done_err  out  1  valid with done; OR of all beat errors in the command
busy  out  1  command in progress
PADDR  out  ADDR_WIDTH  APB address
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERROR  in  1  APB slave error, sampled with PREADY

Behaviour:
- All outputs registered except cmd_ready and wr_ready, which are decoded from the state register.
- Reset (resetn=0 at a clk edge, including mid-command): state=IDLE; all outputs 0, except cmd_ready=1 in IDLE. Any in-flight beat is abandoned and no done pulse is issued.
- IDLE: cmd_ready=1, busy=0.
  - On accept: latch addr, write, len; beat=0; err_acc=0; busy=1.
  - Next state is FETCH if write, else SETUP.
- FETCH: wr_ready=1, PSEL=0.
  - On wr_valid: PWDATA<=wr_data; go to SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0; PADDR, PWRITE stable. Go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1; hold all APB outputs until PREADY=1.
  - On PREADY: err_acc|=PSLVERROR; PSEL, PENABLE <=0.
  - Read: rd_data<=PRDATA, rd_err<=PSLVERROR, rd_valid<=1; go to RESP.
  - Write: go to NEXT.
- RESP: hold rd_valid, rd_data, rd_err until rd_ready=1. On the handshake, rd_valid<=0; go to NEXT.
- NEXT (1 cycle):
  - If beat==len: done<=1 for one cycle, done_err<=err_acc, busy<=0; go to IDLE.
  - Otherwise: PADDR+=DATA_WIDTH/8 (modulo 2^ADDR_WIDTH, wraps silently), beat++; go to FETCH or SETUP.
- PSEL is low for at least one cycle between beats; there are no back-to-back SETUPs.
- PSLVERROR does not abort the burst; remaining beats still run.
- Minimum latency per beat:
  - Read with PREADY=1 in the first ACCESS cycle and rd_ready=1: 4 cycles (SETUP, ACCESS, RESP, NEXT).
  - Write with wr_valid already high: 4 cycles (FETCH, SETUP, ACCESS, NEXT).
- cmd_len=0 means one beat; cmd_len=2^LEN_WIDTH-1 means 2^LEN_WIDTH beats.
- PRDATA and PSLVERROR are ignored unless ACCESS & PREADY.
- cmd_valid while busy is not accepted (cmd_ready=0).

Optional Feature:
- Macro: APB3_MASTER_TIMEOUT_EN.
- Defined:
  - An 8..16-bit cycle counter clears on SETUP and counts in ACCESS.
  - If it reaches TIMEOUT without PREADY, the beat terminates as if PREADY=1 and PSLVERROR=1, with rd_data=0 for reads.
  - PSEL and PENABLE drop, and the burst continues.
- Undefined: ACCESS waits for PREADY indefinitely; no counter logic is present.

Test Plan:
- Single write: cmd addr=0x0010, write, len=0; wr_data=0xDEADBEEF; slave PREADY immediate -> one SETUP then ACCESS with PADDR=0x0010, PWRITE=1, PWDATA=0xDEADBEEF; done=1, done_err=0 on the cycle after NEXT.
- Read burst with backpressure: addr=0x0100, read, len=3; slave returns 0x11,0x22,0x33,0x44 with 2 wait states each; rd_ready low 3 cycles per beat -> PADDR sequence 0x100/104/108/10C; rd_data order preserved and held stable while rd_valid & !rd_ready; done once.
- Error mid-burst: write len=2, PSLVERROR=1 on beat 1 only -> all 3 beats issued; done_err=1. Same as a read -> rd_err=0,1,0.
- Address wrap: addr=0xFFFC, read, len=1 -> second PADDR=0x0000.
- Reset mid-ACCESS: resetn low while PSEL=PENABLE=1 -> next edge all APB outputs 0, cmd_ready=1, no done pulse; a new command then completes normally.
- Timeout (macro on, TIMEOUT=8): slave never asserts PREADY -> after 8 ACCESS cycles the beat ends with rd_valid=1, rd_data=0, rd_err=1, then done_err=1. Macro off: PSEL held indefinitely.
